// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the fetch stage and later pipeline stages.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  // Control fields beyond the register/instruction fields are filled in by decode.
  typedef struct packed {
    lc3b_word inst;
    lc3b_word pc;
    lc3b_reg  dr_sr;
    lc3b_reg  sr1;
    lc3b_reg  sr2;
    logic     sr2_mux_sel;
    logic     load_regfile;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     valid;
  } lc3b_ipacket;

  localparam lc3b_ipacket IPACKET_BUBBLE = '0;

  function automatic lc3b_word pc_inc(input lc3b_word pc);
    return pc + 16'd2;
  endfunction

  function automatic lc3b_word word_align(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// Combinational extraction of instruction fields from a fetched word into an IF/ID packet.
module fetch_decode
  import lc3b_types::*;
(
  input  lc3b_word    word,
  input  lc3b_word    fetch_pc,
  output lc3b_ipacket packet
);

  always_comb begin
    packet             = IPACKET_BUBBLE;
    packet.inst        = word;
    packet.pc          = pc_inc(fetch_pc);
    packet.dr_sr       = word[11:9];
    packet.sr1         = word[8:6];
    packet.sr2         = word[2:0];
    packet.sr2_mux_sel = word[5];
    packet.valid       = 1'b1;
  end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch: one outstanding imem read, one-entry skid buffer, branch squash.
//   state    | meaning
//   S_FETCH  | request at pc outstanding; response decoded into out or skid
//   S_HOLD   | skid buffer full, no request, waiting for stall to drop
//   S_SQUASH | redirected while a read was in flight; next response is dropped
module fetch_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  lc3b_word    br_target,
  input  logic        imem_resp,
  input  lc3b_word    imem_rdata,
  output logic        imem_read,
  output lc3b_word    imem_address,
  output lc3b_ipacket ipacket_out
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_SQUASH = 2'd2
  } state_e;

  state_e      state, state_n;
  lc3b_word    pc, pc_n;
  lc3b_word    req_addr, req_addr_n;
  lc3b_ipacket out_pkt, out_pkt_n;
  lc3b_ipacket skid_pkt, skid_pkt_n;
  lc3b_ipacket dec_pkt;

  fetch_decode u_decode (
    .word     (imem_rdata),
    .fetch_pc (pc),
    .packet   (dec_pkt)
  );

  // The squashed read keeps its original address until memory answers it.
  always_comb begin
    imem_read    = !reset && (state != S_HOLD);
    imem_address = (state == S_SQUASH) ? req_addr : pc;
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    out_pkt_n  = out_pkt;
    skid_pkt_n = skid_pkt;

    if (br_taken) begin
      out_pkt_n  = IPACKET_BUBBLE;
      skid_pkt_n = IPACKET_BUBBLE;
      pc_n       = word_align(br_target);
      case (state)
        S_FETCH: begin
          if (!imem_resp) begin
            state_n    = S_SQUASH;
            req_addr_n = pc;
          end
        end
        S_HOLD:   state_n = S_FETCH;
        S_SQUASH: if (imem_resp) state_n = S_FETCH;
        default:  state_n = S_FETCH;
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_resp) begin
            pc_n = pc_inc(pc);
            if (stall) begin
              skid_pkt_n = dec_pkt;
              state_n    = S_HOLD;
            end else begin
              out_pkt_n = dec_pkt;
            end
          end else if (!stall) begin
            out_pkt_n = IPACKET_BUBBLE;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            out_pkt_n  = skid_pkt;
            skid_pkt_n = IPACKET_BUBBLE;
            state_n    = S_FETCH;
          end
        end
        S_SQUASH: begin
          if (imem_resp) state_n = S_FETCH;
          if (!stall) out_pkt_n = IPACKET_BUBBLE;
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      out_pkt  <= IPACKET_BUBBLE;
      skid_pkt <= IPACKET_BUBBLE;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      out_pkt  <= out_pkt_n;
      skid_pkt <= skid_pkt_n;
    end
  end

  assign ipacket_out = out_pkt;

endmodule
